seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//  Shares the single 8-digit seven-segment display driver between four requesters
//  (e.g. PC, ALU result, debug counter, error code). Round-robin arbitration with a
//  minimum dwell time per owner. Registered 32-bit value feeds the display driver's
//  data input. Sits between system status sources and the display driver.
// PARAMETERS
//  DWELL_CLOCKS  100_000_000  min clocks an owner keeps the display once granted (>=2)
// PORTS
//  clk      in   1    system clock, all state on posedge
//  rst_i    in   1    asynchronous active-high reset
//  req_i    in   4    level request per requester; bit k = requester k
//  data_i   in   128  requester k value on data_i[32*k +: 32]
//  grant_o  out  4    one-hot current owner, 0 when idle (registered)
//  owner_o  out  2    index of current/last owner (registered)
//  data_o   out  32   value to display driver (registered)
//  blank_o  out  1    1 = no owner, display shows 0 (registered)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, grant_o=0, owner_o=0, data_o=0,
//    blank_o=1, dwell cnt=0, RR pointer last=3 (first search starts at 0).
//  - cnt width $clog2(DWELL_CLOCKS+1); counts 0..DWELL_CLOCKS-1, no overflow.
//  - RR pick: first set req_i bit scanning last+1, last+2, ... mod 4 (3 wraps to 0).
//    On every grant: last<=winner, owner_o<=winner, grant_o<=1<<winner, cnt<=0.
//  - IDLE: if req_i!=0 -> pick, go SHOW next edge (req to grant_o latency 1 clk);
//    else stay, grant_o=0, blank_o=1, data_o=0.
//  - SHOW, each clk: data_o<=data_i slice of owner (live-tracked, 1-clk registered);
//    data_o and grant_o always change on the same edge (mux uses next owner).
//    a) owner req dropped: pick among remaining reqs -> SHOW new owner next edge;
//       none -> IDLE (grant_o=0, blank_o=1, data_o=0). Dwell ignored.
//    b) cnt==DWELL_CLOCKS-1 (expiry): other req pending -> RR switch, no idle gap;
//       only owner requesting -> keep owner, cnt<=0; none -> IDLE.
//    c) otherwise cnt<=cnt+1, owner unchanged.
//  - Expiry and owner drop in same cycle: handled as (a).
//  - Non-owner req changes during dwell: no effect until (a)/(b).
//  - blank_o = (state==IDLE); owner_o holds last owner while IDLE.
//  - States: IDLE=0, SHOW=1; no other reachable states.
// CONFIGURATION
//  SEG_ARB_PREEMPT0_EN defined: in SHOW with owner!=0, req_i[0]==1 -> next edge
//    grant to requester 0 (last=0, cnt=0) regardless of dwell; ownership by 0
//    then follows normal rules; preemption check has priority over (a)/(b).
//  Not defined: requester 0 arbitrated identically to 1..3; no preemption logic.
// TESTING (DWELL_CLOCKS=4 in bench)
//  1 Reset: assert rst_i mid-SHOW between edges -> grant_o=0, blank_o=1, data_o=0
//    immediately; deassert, req_i=4'b0001 -> grant_o=4'b0001 after 1 clk.
//  2 Single: req_i=4'b0100, data_i[95:64]=32'hDEADBEEF -> next edge grant_o=4'b0100,
//    owner_o=2, data_o=32'hDEADBEEF, blank_o=0; held 20 clks unchanged; change
//    slice to 32'h12345678 -> data_o follows 1 clk later.
//  3 Round-robin: req_i=4'b1111 constant -> owners 0,1,2,3,0 each exactly 4 clks,
//    no idle cycle between owners.
//  4 Drop: owner 1 at cnt=1, req_i 4'b1010 -> 4'b1000 -> next edge owner_o=3;
//    then req_i=0 -> next edge grant_o=0, blank_o=1, data_o=0.
//  5 Wrap: owner 3 expires with req_i=4'b1001 -> owner_o=0; then req_i=4'b0001
//    -> owner 0 retained across repeated expiries.
//  6 SEG_ARB_PREEMPT0_EN: owner 2 at cnt=0, raise req_i[0] -> next edge
//    grant_o=4'b0001; without macro owner 2 keeps 4 clks, then 0 granted.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbiter for the shared 8-digit seven-segment display, with a minimum dwell per owner.
// Optional build macro SEG_ARB_PREEMPT0_EN lets requester 0 preempt any other owner at once.
module seg_display_arbiter #(
  parameter int unsigned DWELL_CLOCKS = 100_000_000
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic [3:0]   req_i,
  input  logic [127:0] data_i,
  output logic [3:0]   grant_o,
  output logic [1:0]   owner_o,
  output logic [31:0]  data_o,
  output logic         blank_o
);

  localparam int unsigned CNT_W = $clog2(DWELL_CLOCKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CLOCKS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       owner_q, owner_d;
  logic [3:0]       grant_q, grant_d;
  logic [31:0]      data_q, data_d;
  logic             blank_q, blank_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       pick;
  logic             grant_en;
  logic [1:0]       winner;
  logic             preempt;
  logic             owner_dropped;
  logic             dwell_expired;
  logic [31:0]      slice [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign slice[gi] = data_i[32*gi +: 32];
    end
  endgenerate

  // Returns {found, index}: first set request scanning last+1, last+2, ... modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign pick          = rr_pick(req_i, last_q);
  assign owner_dropped = !req_i[owner_q];
  assign dwell_expired = (cnt_q == CNT_MAX);

`ifdef SEG_ARB_PREEMPT0_EN
  assign preempt = (state_q == SHOW) && (owner_q != 2'd0) && req_i[0];
`else
  assign preempt = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and arbitration decision
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    winner   = owner_q;
    case (state_q)
      IDLE: begin
        if (pick[2]) begin
          state_d  = SHOW;
          grant_en = 1'b1;
          winner   = pick[1:0];
        end
      end
      SHOW: begin
        if (preempt) begin
          grant_en = 1'b1;
          winner   = 2'd0;
        end else if (owner_dropped || dwell_expired) begin
          // The owner is scanned last, so it is re-picked only when nobody else waits.
          if (pick[2]) begin
            grant_en = 1'b1;
            winner   = pick[1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; data mux follows the next owner so data and grant move together.
  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = 4'b0000;
    data_d  = 32'h0000_0000;
    blank_d = 1'b1;
    cnt_d   = '0;
    if (state_d == SHOW) begin
      if (grant_en) begin
        owner_d = winner;
        last_d  = winner;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      grant_d = 4'b0001 << owner_d;
      data_d  = slice[owner_d];
      blank_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      last_q  <= 2'd3;
      owner_q <= 2'd0;
      grant_q <= 4'b0000;
      data_q  <= 32'h0000_0000;
      blank_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign owner_o = owner_q;
  assign data_o  = data_q;
  assign blank_o = blank_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with DWELL_CLOCKS=4; honours SEG_ARB_PREEMPT0_EN if defined.
module tb_seg_display_arbiter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [3:0]   req_i;
  logic [127:0] data_i;
  logic [3:0]   grant_o;
  logic [1:0]   owner_o;
  logic [31:0]  data_o;
  logic         blank_o;

  int errors = 0;
  int checks = 0;

  seg_display_arbiter #(.DWELL_CLOCKS(4)) dut (
    .clk     (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .grant_o (grant_o),
    .owner_o (owner_o),
    .data_o  (data_o),
    .blank_o (blank_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                         input logic [31:0] ed, input logic eb);
    chk({tag, ".grant"}, {28'd0, grant_o}, {28'd0, eg});
    chk({tag, ".owner"}, {30'd0, owner_o}, {30'd0, eo});
    chk({tag, ".data"},  data_o, ed);
    chk({tag, ".blank"}, {31'd0, blank_o}, {31'd0, eb});
    $display("step %s: grant=%b owner=%0d data=%h blank=%b", tag, grant_o, owner_o, data_o, blank_o);
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] eo;

    rst_i  = 1'b1;
    req_i  = 4'b0000;
    data_i = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    #1;
    chk_out("reset_async", 4'b0000, 2'd0, 32'h0, 1'b1);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk_out("idle_no_req", 4'b0000, 2'd0, 32'h0, 1'b1);

    // Single requester, held across several dwell expiries
    data_i[95:64] = 32'hDEAD_BEEF;
    req_i = 4'b0100;
    tick();
    chk_out("single_grant", 4'b0100, 2'd2, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out($sformatf("single_hold%0d", i), 4'b0100, 2'd2, 32'hDEAD_BEEF, 1'b0);
    end
    data_i[95:64] = 32'h1234_5678;
    #1;
    chk("single_data_registered", data_o, 32'hDEAD_BEEF);
    tick();
    chk("single_data_follow", data_o, 32'h1234_5678);

    // Asynchronous reset between edges while showing
    #1 rst_i = 1'b1;
    #1;
    chk_out("reset_mid_show", 4'b0000, 2'd0, 32'h0, 1'b1);
    #2 rst_i = 1'b0;
    req_i = 4'b0001;
    tick();
    chk_out("post_reset_grant", 4'b0001, 2'd0, 32'hA000_0000, 1'b0);

    // Round-robin with all requesting: 4 clocks each, no gaps
    req_i = 4'b1111;
    for (int t = 1; t <= 16; t++) begin
      tick();
      eo = 2'((t / 4) % 4);
      eg = 4'b0001 << eo;
      chk_out($sformatf("rr_t%0d", t), eg, eo, (eo == 2'd2) ? 32'h1234_5678 : (32'hA000_0000 | 32'(eo)), 1'b0);
    end

    // Owner drop: owner 0 drops -> 1; owner 1 drops at cnt=1 -> 3; all drop -> idle
    req_i = 4'b1010;
    tick();
    chk_out("drop_to1", 4'b0010, 2'd1, 32'hA000_0001, 1'b0);
    tick();
    chk_out("drop_own1_cnt1", 4'b0010, 2'd1, 32'hA000_0001, 1'b0);
    req_i = 4'b1000;
    tick();
    chk_out("drop_to3", 4'b1000, 2'd3, 32'hA000_0003, 1'b0);
    req_i = 4'b0000;
    tick();
    chk_out("drop_idle", 4'b0000, 2'd3, 32'h0, 1'b1);

    // Wrap from owner 3 to owner 0 at expiry
    req_i = 4'b1000;
    tick();
    chk_out("wrap_own3", 4'b1000, 2'd3, 32'hA000_0003, 1'b0);
    req_i = 4'b1001;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_out($sformatf("wrap_hold3_%0d", i), 4'b1000, 2'd3, 32'hA000_0003, 1'b0);
    end
    tick();
    chk_out("wrap_to0", 4'b0001, 2'd0, 32'hA000_0000, 1'b0);
    req_i = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_out($sformatf("keep0_%0d", i), 4'b0001, 2'd0, 32'hA000_0000, 1'b0);
    end

    // Requester 0 raised while owner 2 is at cnt=0
    req_i = 4'b0100;
    tick();
    chk_out("pre_own2", 4'b0100, 2'd2, 32'h1234_5678, 1'b0);
    req_i = 4'b0101;
`ifdef SEG_ARB_PREEMPT0_EN
    tick();
    chk_out("preempt_to0", 4'b0001, 2'd0, 32'hA000_0000, 1'b0);
`else
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_out($sformatf("nopreempt_hold%0d", i), 4'b0100, 2'd2, 32'h1234_5678, 1'b0);
    end
    tick();
    chk_out("nopreempt_to0", 4'b0001, 2'd0, 32'hA000_0000, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
